// File: rtl/mux_pkg.sv
// Shared select-code definitions for the 3:1 word multiplexer.
// Imported by the core select and the registered wrapper.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_IN0 = 2'b00;
  localparam sel_t SEL_IN1 = 2'b01;
  localparam sel_t SEL_IN2 = 2'b10;
  localparam sel_t SEL_INV = 2'b11;

endpackage

// File: rtl/mux3_core.sv
// Combinational WIDTH-bit 3:1 select.
// The unused select code yields an all-zero word.
module mux3_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in0_i,
  input  logic [WIDTH-1:0] in1_i,
  input  logic [WIDTH-1:0] in2_i,
  input  sel_t             sel_i,
  output logic [WIDTH-1:0] out_o
);

  always_comb begin
    out_o = '0;
    case (sel_i)
      SEL_IN0: out_o = in0_i;
      SEL_IN1: out_o = in1_i;
      SEL_IN2: out_o = in2_i;
      default: out_o = '0;
    endcase
  end

endmodule

// File: rtl/mux3_32b.sv
// 3:1 word mux with combinational result, invalid-select flag,
// and a one-cycle registered copy of both.
module mux3_32b
  import mux_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] input0,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic [1:0]       control,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic             sel_invalid,
  output logic             sel_invalid_q
);

  logic [WIDTH-1:0] out_d;
  logic             inv_d;

  mux3_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .in0_i (input0),
    .in1_i (input1),
    .in2_i (input2),
    .sel_i (sel_t'(control)),
    .out_o (out_d)
  );

  assign inv_d       = (sel_t'(control) == SEL_INV);
  assign out         = out_d;
  assign sel_invalid = inv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q         <= '0;
      sel_invalid_q <= 1'b0;
    end else begin
      out_q         <= out_d;
      sel_invalid_q <= inv_d;
    end
  end

endmodule

// File: tb/tb_mux3_32b.sv
// Directed bench for mux3_32b: combinational checks inline,
// registered outputs checked through an expected-value queue.
module tb_mux3_32b;

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input0, input1, input2;
  logic [1:0]  control;
  logic [31:0] out, out_q;
  logic        sel_invalid, sel_invalid_q;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  mux3_32b dut (
    .clk           (clk),
    .rst           (rst),
    .input0        (input0),
    .input1        (input1),
    .input2        (input2),
    .control       (control),
    .out           (out),
    .out_q         (out_q),
    .sel_invalid   (sel_invalid),
    .sel_invalid_q (sel_invalid_q)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] d);
    exp_t e;
    e.inv = (c == 2'b11);
    if (c == 2'b00)      e.data = a;
    else if (c == 2'b01) e.data = b;
    else if (c == 2'b10) e.data = d;
    else                 e.data = 32'h0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_comb(input string tag);
    exp_t e;
    e = model(control, input0, input1, input2);
    chk({tag, "_out"}, out, e.data);
    chk({tag, "_inv"}, {31'b0, sel_invalid}, {31'b0, e.inv});
  endtask

  // Push the expectation for the coming edge, then pop and compare after it.
  task automatic tick(input string tag);
    exp_t e;
    sb.push_back(model(control, input0, input1, input2));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_outq"}, out_q, e.data);
      chk({tag, "_invq"}, {31'b0, sel_invalid_q}, {31'b0, e.inv});
    end
  endtask

  initial begin
    rst     = 1'b1;
    input0  = 32'h55555555;
    input1  = 32'h0000FFFF;
    input2  = 32'hFFFF0000;
    control = 2'b00;
    #2;
    chk("rst_outq", out_q, 32'h0);
    chk("rst_invq", {31'b0, sel_invalid_q}, 32'h0);
    chk_comb("rst_comb");
    @(posedge clk);
    #1;
    chk("rst_hold_outq", out_q, 32'h0);
    #2 rst = 1'b0;
    #1;

    chk_comb("sel0");
    tick("sel0");
    control = 2'b01; #1 chk_comb("sel1");
    tick("sel1");
    control = 2'b10; #1 chk_comb("sel2");
    tick("sel2");
    control = 2'b00; #1 chk_comb("sel0b");
    tick("sel0b");
    control = 2'b11; #1 chk_comb("inv");
    chk("inv_out_zero", out, 32'h0);
    tick("inv");

    // Reset mid-cycle with the invalid flag registered high.
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outq", out_q, 32'h0);
    chk("rst_mid_invq", {31'b0, sel_invalid_q}, 32'h0);
    chk_comb("rst_mid_comb");
    #2 rst = 1'b0;

    control = 2'b01;
    tick("sel1_pre");
    chk("pre_outq", out_q, 32'h0000FFFF);
    #1 rst = 1'b1;
    #1;
    chk("rst2_outq", out_q, 32'h0);
    chk("rst2_invq", {31'b0, sel_invalid_q}, 32'h0);
    chk("rst2_out", out, 32'h0000FFFF);
    @(posedge clk);
    #1;
    chk("rst2_hold", out_q, 32'h0);
    #1 rst = 1'b0;
    #1 input1 = 32'hDEADBEEF;
    #1;
    chk_comb("dead");
    chk("dead_out", out, 32'hDEADBEEF);
    chk("dead_outq_wait", out_q, 32'h0);
    tick("dead");

    for (int i = 0; i < 12; i++) begin
      input0  = $urandom;
      input1  = $urandom;
      input2  = $urandom;
      control = 2'($urandom_range(0, 3));
      #1 chk_comb("rnd");
      tick("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
